alarm_clock_multi: RTL and testbench

Parametrised successor to the single-alarm clock top level. It keeps time as seconds, minutes, hours and day-of-week, and holds NUM_ALARMS independently settable alarms. Each alarm has a ring/snooze/timeout state machine. Outputs are binary time values for the existing 2-digit lcd_int display drivers, plus a per-alarm and combined buzz.

---
 rtl/alarm_clock_multi.sv | 199 +++++++++++++++++++
 tb/tb_alarm_clock_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_multi.sv
// rtl/alarm_clock_multi.sv - time-of-day clock with NUM_ALARMS ring/snooze alarm slots
// Define TWELVE_HOUR_EN to add the Hrs12/PM display outputs.
module alarm_clock_multi #(
   parameter int NUM_ALARMS = 2,
   parameter int SNOOZE_MIN = 9,
   parameter int RING_SEC   = 60,
   localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  Timeset,
   input  logic                  Alarmset,
   input  logic                  Minadv,
   input  logic                  Hrsadv,
   input  logic [SEL_W-1:0]      alarm_sel,
   input  logic [NUM_ALARMS-1:0] alarm_en,
   input  logic                  Alarmon,
   input  logic                  snooze,
   input  logic                  dismiss,
`ifdef TWELVE_HOUR_EN
   output logic [3:0]            Hrs12,
   output logic                  PM,
`endif
   output logic [6:0]            TSec,
   output logic [6:0]            TMin,
   output logic [6:0]            THrs,
   output logic [2:0]            TDay,
   output logic [6:0]            AMin,
   output logic [6:0]            AHrs,
   output logic [NUM_ALARMS-1:0] buzz_vec,
   output logic                  Buzz
);

   localparam int RING_W = $clog2(RING_SEC + 1);
   localparam int SNZ_W  = $clog2(SNOOZE_MIN * 60 + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RINGING = 2'd1;
   localparam logic [1:0] ST_SNOOZE  = 2'd2;

   logic [6:0] sec_q, sec_d, min_q, min_d, hrs_q, hrs_d;
   logic [2:0] day_q, day_d;
   logic       sec_wrap, min_wrap, hrs_wrap;

   logic [6:0]        amin_q  [NUM_ALARMS];
   logic [6:0]        amin_d  [NUM_ALARMS];
   logic [6:0]        ahrs_q  [NUM_ALARMS];
   logic [6:0]        ahrs_d  [NUM_ALARMS];
   logic [1:0]        state_q [NUM_ALARMS];
   logic [1:0]        state_d [NUM_ALARMS];
   logic [RING_W-1:0] ring_q  [NUM_ALARMS];
   logic [RING_W-1:0] ring_d  [NUM_ALARMS];
   logic [SNZ_W-1:0]  snz_q   [NUM_ALARMS];
   logic [SNZ_W-1:0]  snz_d   [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] match_vec;
   logic                  alarm_wr;

   assign sec_wrap = (sec_q == 7'd59);
   assign min_wrap = (min_q == 7'd59);
   assign hrs_wrap = (hrs_q == 7'd23);

   always_comb begin
      sec_d = sec_q;
      min_d = min_q;
      hrs_d = hrs_q;
      day_d = day_q;
      if (tick) begin
         sec_d = sec_wrap ? 7'd0 : sec_q + 7'd1;
         // In time-adjust mode the buttons step fields independently; no carries.
         if (Timeset) begin
            if (Minadv) min_d = min_wrap ? 7'd0 : min_q + 7'd1;
            if (Hrsadv) hrs_d = hrs_wrap ? 7'd0 : hrs_q + 7'd1;
         end else if (sec_wrap) begin
            min_d = min_wrap ? 7'd0 : min_q + 7'd1;
            if (min_wrap) begin
               hrs_d = hrs_wrap ? 7'd0 : hrs_q + 7'd1;
               if (hrs_wrap) day_d = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
            end
         end
      end
   end

   assign alarm_wr = tick && Alarmset && !Timeset;

   always_comb begin
      AMin = 7'd0;
      AHrs = 7'd0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         amin_d[k] = amin_q[k];
         ahrs_d[k] = ahrs_q[k];
         // An out-of-range selector matches no slot, so it writes nothing and reads 0.
         if (alarm_sel == SEL_W'(k)) begin
            AMin = amin_q[k];
            AHrs = ahrs_q[k];
            if (alarm_wr && Minadv) amin_d[k] = (amin_q[k] == 7'd59) ? 7'd0 : amin_q[k] + 7'd1;
            if (alarm_wr && Hrsadv) ahrs_d[k] = (ahrs_q[k] == 7'd23) ? 7'd0 : ahrs_q[k] + 7'd1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
         match_vec[k] = tick && !Timeset && (sec_q == 7'd0) &&
                        (min_q == amin_q[k]) && (hrs_q == ahrs_q[k]);
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
         state_d[k] = state_q[k];
         ring_d[k]  = ring_q[k];
         snz_d[k]   = snz_q[k];
         if (!Alarmon || !alarm_en[k]) begin
            state_d[k] = ST_IDLE;
         end else begin
            case (state_q[k])
               ST_IDLE: begin
                  if (match_vec[k]) begin
                     state_d[k] = ST_RINGING;
                     ring_d[k]  = '0;
                  end
               end
               ST_RINGING: begin
                  if (dismiss) begin
                     state_d[k] = ST_IDLE;
                  end else if (snooze) begin
                     state_d[k] = ST_SNOOZE;
                     snz_d[k]   = SNZ_W'(SNOOZE_MIN * 60);
                  end else if (tick) begin
                     ring_d[k] = ring_q[k] + RING_W'(1);
                     if (ring_q[k] == RING_W'(RING_SEC - 1)) state_d[k] = ST_IDLE;
                  end
               end
               ST_SNOOZE: begin
                  if (dismiss) begin
                     state_d[k] = ST_IDLE;
                  end else if (match_vec[k] || (tick && snz_q[k] == SNZ_W'(1))) begin
                     state_d[k] = ST_RINGING;
                     ring_d[k]  = '0;
                     snz_d[k]   = '0;
                  end else if (tick) begin
                     snz_d[k] = snz_q[k] - SNZ_W'(1);
                  end
               end
               default: state_d[k] = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sec_q <= 7'd0;
         min_q <= 7'd0;
         hrs_q <= 7'd0;
         day_q <= 3'd0;
         for (int k = 0; k < NUM_ALARMS; k++) begin
            amin_q[k]  <= 7'd0;
            ahrs_q[k]  <= 7'd0;
            state_q[k] <= ST_IDLE;
            ring_q[k]  <= '0;
            snz_q[k]   <= '0;
         end
      end else begin
         sec_q <= sec_d;
         min_q <= min_d;
         hrs_q <= hrs_d;
         day_q <= day_d;
         for (int k = 0; k < NUM_ALARMS; k++) begin
            amin_q[k]  <= amin_d[k];
            ahrs_q[k]  <= ahrs_d[k];
            state_q[k] <= state_d[k];
            ring_q[k]  <= ring_d[k];
            snz_q[k]   <= snz_d[k];
         end
      end
   end

   // Buzz decodes straight from the state registers so it adds no pipeline stage.
   always_comb begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
         buzz_vec[k] = (state_q[k] == ST_RINGING);
      end
   end

   assign Buzz = |buzz_vec;
   assign TSec = sec_q;
   assign TMin = min_q;
   assign THrs = hrs_q;
   assign TDay = day_q;

`ifdef TWELVE_HOUR_EN
   assign Hrs12 = (hrs_q == 7'd0)  ? 4'd12 :
                  (hrs_q > 7'd12)  ? 4'(hrs_q - 7'd12) : hrs_q[3:0];
   assign PM    = (hrs_q >= 7'd12);
`endif

endmodule

// File: tb/tb_alarm_clock_multi.sv
// tb/tb_alarm_clock_multi.sv - directed self-checking bench for alarm_clock_multi
module tb_alarm_clock_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       Timeset = 1'b0;
   logic       Alarmset = 1'b0;
   logic       Minadv = 1'b0;
   logic       Hrsadv = 1'b0;
   logic [0:0] alarm_sel = 1'b0;
   logic [1:0] alarm_en = 2'b00;
   logic       Alarmon = 1'b0;
   logic       snooze = 1'b0;
   logic       dismiss = 1'b0;
   logic [6:0] TSec, TMin, THrs, AMin, AHrs;
   logic [2:0] TDay;
   logic [1:0] buzz_vec;
   logic       Buzz;
`ifdef TWELVE_HOUR_EN
   logic [3:0] Hrs12;
   logic       PM;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   alarm_clock_multi dut (
      .clk(clk), .rst(rst), .tick(tick), .Timeset(Timeset), .Alarmset(Alarmset),
      .Minadv(Minadv), .Hrsadv(Hrsadv), .alarm_sel(alarm_sel), .alarm_en(alarm_en),
      .Alarmon(Alarmon), .snooze(snooze), .dismiss(dismiss),
`ifdef TWELVE_HOUR_EN
      .Hrs12(Hrs12), .PM(PM),
`endif
      .TSec(TSec), .TMin(TMin), .THrs(THrs), .TDay(TDay), .AMin(AMin), .AHrs(AHrs),
      .buzz_vec(buzz_vec), .Buzz(Buzz)
   );

   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic do_reset();
      Timeset = 0; Alarmset = 0; Minadv = 0; Hrsadv = 0; alarm_sel = 0;
      alarm_en = 0; Alarmon = 0; snooze = 0; dismiss = 0; tick = 0;
      rst = 1'b0;
      #2;
      rst = 1'b1;
      cycles(1);
   endtask

   // Leaves slot 1 armed for 07:30 with the clock showing 07:29:59.
   task automatic setup_0730();
      do_reset();
      Alarmset = 1; alarm_sel = 1;
      Hrsadv = 1; ticks(7); Hrsadv = 0;
      Minadv = 1; ticks(30); Minadv = 0;
      Alarmset = 0;
      Timeset = 1;
      Hrsadv = 1; ticks(7); Hrsadv = 0;
      Minadv = 1; ticks(29); Minadv = 0;
      Timeset = 0;
      alarm_en = 2'b10; Alarmon = 1;
      ticks(46);
   endtask

   task automatic test_reset();
      cycles(1);
      total_cnt++; if ({TSec, TMin, THrs, TDay} !== 24'd0) $display("FAIL reset_time: got %0d:%0d:%0d d%0d expected 0:0:0 d0", THrs, TMin, TSec, TDay); else pass_cnt++;
      total_cnt++; if ({AHrs, AMin} !== 14'd0) $display("FAIL reset_alarm: got %0d:%0d expected 0:0", AHrs, AMin); else pass_cnt++;
      total_cnt++; if ({buzz_vec, Buzz} !== 3'b000) $display("FAIL reset_buzz: got %b/%b expected 00/0", buzz_vec, Buzz); else pass_cnt++;
      rst = 1'b1;
      cycles(1);
   endtask

   task automatic test_day_wrap();
      do_reset();
      ticks(3661);
      total_cnt++; if ({THrs, TMin, TSec} !== {7'd1, 7'd1, 7'd1}) $display("FAIL run_3661: got %0d:%0d:%0d expected 1:1:1", THrs, TMin, TSec); else pass_cnt++;
      ticks(86400 - 3661);
      total_cnt++; if ({THrs, TMin, TSec} !== 21'd0) $display("FAIL day_wrap_time: got %0d:%0d:%0d expected 0:0:0", THrs, TMin, TSec); else pass_cnt++;
      total_cnt++; if (TDay !== 3'd1) $display("FAIL day_wrap_day: got %0d expected 1", TDay); else pass_cnt++;
      ticks(5);
      rst = 1'b0;
      #1;
      total_cnt++; if ({TSec, TMin, THrs, TDay, Buzz} !== 25'd0) $display("FAIL async_reset: got %0d:%0d:%0d d%0d expected all 0", THrs, TMin, TSec, TDay); else pass_cnt++;
      rst = 1'b1;
      cycles(1);
   endtask

   task automatic test_timeset();
      do_reset();
      Timeset = 1; Minadv = 1;
      ticks(59);
      total_cnt++; if ({THrs, TMin, TSec} !== {7'd0, 7'd59, 7'd59}) $display("FAIL set_min_59: got %0d:%0d:%0d expected 0:59:59", THrs, TMin, TSec); else pass_cnt++;
      ticks(2);
      total_cnt++; if ({THrs, TMin} !== {7'd0, 7'd1}) $display("FAIL set_min_wrap: got %0d:%0d expected 0:1", THrs, TMin); else pass_cnt++;
      Minadv = 0; Hrsadv = 1;
      ticks(23);
      total_cnt++; if (THrs !== 7'd23) $display("FAIL set_hrs_23: got %0d expected 23", THrs); else pass_cnt++;
      ticks(1);
      total_cnt++; if ({THrs, TDay, TMin} !== {7'd0, 3'd0, 7'd1}) $display("FAIL set_hrs_wrap: got h%0d d%0d m%0d expected h0 d0 m1", THrs, TDay, TMin); else pass_cnt++;
      Minadv = 1;
      ticks(1);
      total_cnt++; if ({THrs, TMin} !== {7'd1, 7'd2}) $display("FAIL set_both: got %0d:%0d expected 1:2", THrs, TMin); else pass_cnt++;
      Minadv = 0; Hrsadv = 0; Timeset = 0;
      cycles(5);
      total_cnt++; if (TSec !== 7'd26) $display("FAIL hold_no_tick: got %0d expected 26", TSec); else pass_cnt++;
   endtask

   task automatic test_alarmset();
      do_reset();
      Alarmset = 1; alarm_sel = 1;
      Hrsadv = 1; ticks(7); Hrsadv = 0;
      Minadv = 1; ticks(30); Minadv = 0;
      Alarmset = 0;
      total_cnt++; if ({AHrs, AMin} !== {7'd7, 7'd30}) $display("FAIL alarm1_set: got %0d:%0d expected 7:30", AHrs, AMin); else pass_cnt++;
      total_cnt++; if ({THrs, TMin, TSec} !== {7'd0, 7'd0, 7'd37}) $display("FAIL alarm_set_time: got %0d:%0d:%0d expected 0:0:37", THrs, TMin, TSec); else pass_cnt++;
      alarm_sel = 0;
      #1;
      total_cnt++; if ({AHrs, AMin} !== 14'd0) $display("FAIL alarm0_untouched: got %0d:%0d expected 0:0", AHrs, AMin); else pass_cnt++;
      alarm_sel = 1; Timeset = 1; Alarmset = 1; Minadv = 1;
      ticks(1);
      Timeset = 0; Alarmset = 0; Minadv = 0;
      total_cnt++; if ({AMin, TMin} !== {7'd30, 7'd1}) $display("FAIL timeset_priority: got amin %0d tmin %0d expected 30 1", AMin, TMin); else pass_cnt++;
   endtask

   task automatic test_ring_timeout();
      setup_0730();
      total_cnt++; if ({THrs, TMin, TSec, Buzz} !== {7'd7, 7'd29, 7'd59, 1'b0}) $display("FAIL pre_alarm: got %0d:%0d:%0d buzz %b expected 7:29:59 0", THrs, TMin, TSec, Buzz); else pass_cnt++;
      ticks(2);
      total_cnt++; if ({buzz_vec, Buzz} !== 3'b101) $display("FAIL ring_start: got %b/%b expected 10/1", buzz_vec, Buzz); else pass_cnt++;
      ticks(59);
      total_cnt++; if (Buzz !== 1'b1) $display("FAIL ring_59: got %b expected 1", Buzz); else pass_cnt++;
      ticks(1);
      total_cnt++; if ({buzz_vec, Buzz} !== 3'b000) $display("FAIL ring_timeout: got %b/%b expected 00/0", buzz_vec, Buzz); else pass_cnt++;
   endtask

   task automatic test_snooze();
      setup_0730();
      ticks(2);
      ticks(3);
      snooze = 1; cycles(1); snooze = 0;
      total_cnt++; if (Buzz !== 1'b0) $display("FAIL snooze_enter: got %b expected 0", Buzz); else pass_cnt++;
      ticks(539);
      total_cnt++; if (Buzz !== 1'b0) $display("FAIL snooze_539: got %b expected 0", Buzz); else pass_cnt++;
      ticks(1);
      total_cnt++; if ({buzz_vec, Buzz} !== 3'b101) $display("FAIL snooze_rering: got %b/%b expected 10/1", buzz_vec, Buzz); else pass_cnt++;
      snooze = 1; dismiss = 1; cycles(1); snooze = 0; dismiss = 0;
      total_cnt++; if (Buzz !== 1'b0) $display("FAIL dismiss_wins: got %b expected 0", Buzz); else pass_cnt++;
      ticks(600);
      total_cnt++; if (Buzz !== 1'b0) $display("FAIL no_rering: got %b expected 0", Buzz); else pass_cnt++;
   endtask

   task automatic test_two_slots();
      do_reset();
      Alarmset = 1; Hrsadv = 1;
      alarm_sel = 0; ticks(6);
      alarm_sel = 1; ticks(6);
      Hrsadv = 0; Alarmset = 0;
      Timeset = 1;
      Hrsadv = 1; ticks(5); Hrsadv = 0;
      Minadv = 1; ticks(59); Minadv = 0;
      Timeset = 0;
      alarm_en = 2'b11; Alarmon = 1;
      ticks(43);
      total_cnt++; if ({THrs, TMin, TSec, Buzz} !== {7'd5, 7'd59, 7'd59, 1'b0}) $display("FAIL two_pre: got %0d:%0d:%0d buzz %b expected 5:59:59 0", THrs, TMin, TSec, Buzz); else pass_cnt++;
      ticks(2);
      total_cnt++; if ({buzz_vec, Buzz} !== 3'b111) $display("FAIL two_ring: got %b/%b expected 11/1", buzz_vec, Buzz); else pass_cnt++;
      Alarmon = 0;
      cycles(1);
      total_cnt++; if ({buzz_vec, Buzz, TSec} !== {3'b000, 7'd1}) $display("FAIL alarmon_off: got %b/%b sec %0d expected 00/0 1", buzz_vec, Buzz, TSec); else pass_cnt++;
   endtask

`ifdef TWELVE_HOUR_EN
   task automatic test_twelve_hour();
      do_reset();
      total_cnt++; if ({Hrs12, PM} !== {4'd12, 1'b0}) $display("FAIL h12_midnight: got %0d pm %b expected 12 0", Hrs12, PM); else pass_cnt++;
      Timeset = 1; Hrsadv = 1;
      ticks(12);
      total_cnt++; if ({Hrs12, PM} !== {4'd12, 1'b1}) $display("FAIL h12_noon: got %0d pm %b expected 12 1", Hrs12, PM); else pass_cnt++;
      ticks(1);
      total_cnt++; if ({Hrs12, PM} !== {4'd1, 1'b1}) $display("FAIL h12_13: got %0d pm %b expected 1 1", Hrs12, PM); else pass_cnt++;
      Timeset = 0; Hrsadv = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_day_wrap();
      test_timeset();
      test_alarmset();
      test_ring_timeout();
      test_snooze();
      test_two_slots();
`ifdef TWELVE_HOUR_EN
      test_twelve_hour();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
